// File: rtl/mem_stream_pkg.sv
// Shared types and constants for the memory stream reader.
package mem_stream_pkg;

  localparam int MEM_AW    = 20;
  localparam int DEFAULT_N = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/mem_stream_reader_sync_fifo.sv
// Synchronous FIFO with occupancy count; simultaneous push and pop keeps the count.
module sync_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests against the current occupancy.
  always_comb begin
    do_pop_s  = pop && (count_r != {(PW+1){1'b0}});
    do_push_s = push && ((count_r != (PW+1)'(DEPTH)) || do_pop_s);
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign empty    = (count_r == {(PW+1){1'b0}});
  assign full     = (count_r == (PW+1)'(DEPTH));
  assign count    = count_r;

endmodule

// File: rtl/mem_stream_reader.sv
// Burst reader: issues consecutive word reads for a (base, length) command and
// returns the data as a valid/ready stream with last-word marking.
module mem_stream_reader
  import mem_stream_pkg::*;
#(
  parameter int N          = DEFAULT_N,
  parameter int AW         = MEM_AW,
  parameter int LEN_W      = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    mem_address,
  output logic             mem_wren,
  output logic [N-1:0]     mem_data,
  input  logic [N-1:0]     mem_q,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t           state_r;
  logic [AW-1:0]    cur_addr_r;
  logic [LEN_W-1:0] remaining_r;
  logic             busy_r;
  logic             done_r;
  logic [AW-1:0]    mem_address_r;
  logic             rd_issued_r;
  logic             rd_last_issued_r;
  logic             rd_valid_r;
  logic             rd_last_valid_r;
  logic             out_valid_r;
  logic             out_last_r;
  logic [N-1:0]     out_data_r;

  logic             fifo_push_s;
  logic             fifo_pop_s;
  logic             fifo_empty_s;
  logic             fifo_full_s;
  logic [CW-1:0]    fifo_count_s;
  logic [N:0]       fifo_push_data_s;
  logic [N:0]       fifo_pop_data_s;

  logic [CW:0]      occupancy_s;
  logic             credit_s;
  logic             issue_s;
  logic             out_load_s;
  logic             drain_done_s;

  // Credit, issue and output-stage handshake decisions.
  always_comb begin
    occupancy_s = (CW+1)'(fifo_count_s) + (CW+1)'(rd_issued_r) + (CW+1)'(rd_valid_r);
    credit_s    = !fifo_full_s && (occupancy_s < (CW+1)'(FIFO_DEPTH));
    case (state_r)
      ISSUE:   issue_s = credit_s;
      default: issue_s = 1'b0;
    endcase
    out_load_s       = !out_valid_r || out_ready;
    fifo_pop_s       = out_load_s && !fifo_empty_s;
    fifo_push_s      = rd_valid_r;
    fifo_push_data_s = {rd_last_valid_r, mem_q};
    // The last beat may be transferring in this very cycle.
    drain_done_s     = (state_r == DRAIN) && !rd_issued_r && !rd_valid_r &&
                       fifo_empty_s && (!out_valid_r || out_ready);
  end

  // Command FSM, read pipeline flags and registered stream output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      cur_addr_r       <= {AW{1'b0}};
      remaining_r      <= {LEN_W{1'b0}};
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      mem_address_r    <= {AW{1'b0}};
      rd_issued_r      <= 1'b0;
      rd_last_issued_r <= 1'b0;
      rd_valid_r       <= 1'b0;
      rd_last_valid_r  <= 1'b0;
      out_valid_r      <= 1'b0;
      out_last_r       <= 1'b0;
      out_data_r       <= {N{1'b0}};
    end else begin
      done_r           <= 1'b0;
      rd_issued_r      <= 1'b0;
      rd_last_issued_r <= 1'b0;
      rd_valid_r       <= rd_issued_r;
      rd_last_valid_r  <= rd_last_issued_r;

      if (out_load_s) begin
        if (!fifo_empty_s) begin
          out_valid_r <= 1'b1;
          out_data_r  <= fifo_pop_data_s[N-1:0];
          out_last_r  <= fifo_pop_data_s[N];
        end else begin
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      end

      case (state_r)
        IDLE: begin
          if (start) begin
            if (length != {LEN_W{1'b0}}) begin
              // The first read issues on the accepting edge to meet start-to-data latency.
              mem_address_r    <= base_addr;
              rd_issued_r      <= 1'b1;
              rd_last_issued_r <= (length == LEN_W'(1));
              cur_addr_r       <= base_addr + AW'(1);
              remaining_r      <= length - LEN_W'(1);
              busy_r           <= 1'b1;
              state_r          <= (length == LEN_W'(1)) ? DRAIN : ISSUE;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue_s) begin
            mem_address_r    <= cur_addr_r;
            rd_issued_r      <= 1'b1;
            rd_last_issued_r <= (remaining_r == LEN_W'(1));
            cur_addr_r       <= cur_addr_r + AW'(1);
            remaining_r      <= remaining_r - LEN_W'(1);
            if (remaining_r == LEN_W'(1)) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_done_s) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (N + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push_s),
    .push_data (fifo_push_data_s),
    .pop       (fifo_pop_s),
    .pop_data  (fifo_pop_data_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s),
    .count     (fifo_count_s)
  );

  assign busy        = busy_r;
  assign done        = done_r;
  assign mem_address = mem_address_r;
  assign mem_wren    = 1'b0;
  assign mem_data    = {N{1'b0}};
  assign out_data    = out_data_r;
  assign out_valid   = out_valid_r;
  assign out_last    = out_last_r;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader with a behavioural memory and stream model.
module tb_mem_stream_reader;

  localparam int N     = 24;
  localparam int AW    = 20;
  localparam int LEN_W = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [LEN_W-1:0] length = '0;
  logic             busy, done, mem_wren, out_valid, out_last;
  logic [AW-1:0]    mem_address;
  logic [N-1:0]     mem_data, out_data;
  logic [N-1:0]     mem_q = '0;
  logic             out_ready = 1'b1;

  mem_stream_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_address(mem_address), .mem_wren(mem_wren),
    .mem_data(mem_data), .mem_q(mem_q), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] data;
    logic         last;
  } beat_t;

  int           total = 0;
  int           bad = 0;
  int           beats = 0;
  int           exp_done = 0;
  int           ready_mode = 0;
  beat_t        exp_q[$];
  beat_t        mon_e;
  logic         prev_stall = 1'b0;
  logic [N-1:0] prev_data = '0;
  logic [N-1:0] preload [logic [AW-1:0]];

  function automatic logic [N-1:0] mem_rd(input logic [AW-1:0] a);
    if (preload.exists(a)) return preload[a];
    return {a[11:0], a[19:8]} ^ 24'h3C5A96;
  endfunction

  // Registered-read memory: data follows the address edge by one cycle.
  always @(posedge clk) mem_q <= mem_rd(mem_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Downstream ready generator: always, 1-0-0 pattern, or random.
  initial begin
    int phase = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (phase == 0);
          phase = (phase + 1) % 3;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares every transferred beat and done pulse against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("wren_zero", {31'd0, mem_wren}, 32'd0);
      chk("wdata_zero", {8'd0, mem_data}, 32'd0);
      chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
      if (prev_stall) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", {8'd0, out_data}, {8'd0, prev_data});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got data %0h while nothing was expected", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_data", {8'd0, out_data}, {8'd0, mon_e.data});
          chk("beat_last", {31'd0, out_last}, {31'd0, mon_e.last});
        end
        beats++;
      end
      if (done) begin
        total++;
        if (exp_done == 0) begin
          bad++;
          $display("FAIL unexpected_done: got done=1 expected done=0");
        end else begin
          exp_done--;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic cmd(input logic [AW-1:0] b, input logic [LEN_W-1:0] len, input bit expect_it);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = b;
    length = len;
    if (expect_it) begin
      for (int i = 0; i < int'(len); i++)
        exp_q.push_back('{data: mem_rd(b + AW'(i)), last: (i == int'(len) - 1)});
      exp_done++;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_done != 0 || exp_q.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (n >= 500) begin
      bad++;
      $display("FAIL burst_timeout: got %0d beats and %0d done pending expected none", exp_q.size(), exp_done);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0;
    int n;
    logic [AW-1:0] ea;
    preload[20'h00010] = 24'h0000A1;
    preload[20'h00011] = 24'h0000B2;
    preload[20'h00012] = 24'h0000C3;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_addr", {12'd0, mem_address}, 32'd0);
    chk("rst_data", {8'd0, out_data}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic burst with start-to-data latency
    ready_mode = 0;
    cmd(20'h00010, 20'd3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("basic_busy", {31'd0, busy}, 32'd1);
        chk("basic_addr", {12'd0, mem_address}, 32'h10);
      end
      chk("basic_latency", {31'd0, out_valid}, {31'd0, (k == 3)});
    end
    wait_idle();

    // Backpressure with ready pattern 1,0,0
    ready_mode = 1;
    cmd(20'h00200, 20'd8, 1'b1);
    wait_idle();
    ready_mode = 0;

    // Address wrap-around
    cmd(20'hFFFFE, 20'd4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ea = 20'hFFFFE + AW'(k);
      chk("wrap_addr", {12'd0, mem_address}, {12'd0, ea});
    end
    wait_idle();

    // Zero length: done next cycle, no access
    cmd(20'h0ABCD, 20'd0, 1'b1);
    @(negedge clk);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_addr", {12'd0, mem_address}, 32'h00001);
    chk("zero_valid", {31'd0, out_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("zero_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
    end
    wait_idle();

    // Reset after the second beat of a six-word burst
    b0 = beats;
    cmd(20'h00300, 20'd6, 1'b1);
    n = 0;
    while (beats < b0 + 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("midrst_reached", {31'd0, (n < 100)}, 32'd1);
    #1;
    rst = 1'b1;
    exp_q.delete();
    exp_done = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (8) begin
      chk("midrst_nodone", {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    cmd(20'h00100, 20'd2, 1'b1);
    wait_idle();

    // Start while busy is ignored
    b0 = beats;
    cmd(20'h00400, 20'd4, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 20'h00500;
    length = 20'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (10) @(posedge clk);
    chk("busy_start_beats", beats - b0, 32'd4);

    // Randomized bursts under random backpressure
    for (int r = 0; r < 8; r++) begin
      ready_mode = (r % 2 == 0) ? 2 : 1;
      cmd(20'($urandom), 20'($urandom_range(1, 12)), 1'b1);
      wait_idle();
    end
    ready_mode = 0;
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stream_reader.md
Name: mem_stream_reader

Overview:
- Sequential burst reader in front of one port of the dual-port main memory (20-bit word address, N-bit words, registered read with 1-cycle latency).
- Takes a (base, length) command and issues consecutive word reads.
- Returns the read data as a valid/ready stream with last-word marking and full backpressure.
- Feeds the downstream compute stages; the memory port's write lines are held inactive.

Parameters:
- N, 24, data word width; matches main memory width.
- AW, 20, memory word-address width.
- LEN_W, 20, width of the length field (word count).
- FIFO_DEPTH, 4, output buffer depth; power of two, minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  AW  first word address.
- length  in  LEN_W  number of words to read.
- busy  out  1  high from command acceptance until done.
- done  out  1  one-cycle pulse when the burst completes.
- mem_address  out  AW  memory port address.
- mem_wren  out  1  memory write enable; constant 0.
- mem_data  out  N  memory write data; constant 0.
- mem_q  in  N  memory read data; valid 1 cycle after the address edge.
- out_data  out  N  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready; a beat transfers on valid&ready.
- out_last  out  1  marks the final word of the burst; qualified by out_valid.

Behaviour:
- Reset values: busy=0, done=0, out_valid=0, out_last=0, mem_address=0, out_data=0. On reset the FIFO, in-flight tracking, and counters clear and the state goes to IDLE.
- Reset mid-burst aborts the burst: no done pulse, and pending data is discarded.
- FSM states:
  - IDLE:
    - start=1 with length!=0 → latch cur_addr=base_addr and remaining=length, set busy, go to ISSUE.
    - start=1 with length==0 → done=1 on the next cycle, no memory access, stay in IDLE.
  - ISSUE: in each cycle where credit is available, drive mem_address=cur_addr, mark a read in flight, cur_addr+=1, remaining-=1.
    - Credit is available when fifo_count + inflight < FIFO_DEPTH.
    - When the last read issues, go to DRAIN.
  - DRAIN: wait until inflight==0, the FIFO is empty, and the last beat has transferred. Then done=1 for one cycle, busy=0, go to IDLE.
- Read return: a read issued in cycle t has mem_q captured into the FIFO at the end of cycle t+1. At most one read is in flight per cycle (1-bit pipeline flag).
- Timing: start sampled at edge E0. mem_address=base during the cycle after E0. out_valid rises after E0+3 edges (3-cycle start-to-data latency). With out_ready held high, throughput is 1 word/cycle.
- out_last:
  - Set on the FIFO entry holding word number length-1.
  - Carried as an extra FIFO bit, i.e. FIFO width N+1.
- Address arithmetic is modulo 2^AW: 0xFFFFF+1 wraps to 0x00000 with no error.
- The FIFO never overflows, because the credit rule is enforced. Simultaneous push and pop in the same cycle is legal and keeps the count unchanged.
- out_data/out_valid come from the FIFO head. out_data is held stable while out_valid=1 and out_ready=0.
- start while busy=1 is ignored; no queuing.
- mem_address holds its last value when no read issues. Memory read data is used only in the cycle after an issue.
- done and busy are never high in the same cycle.

Decomposition:
- Package mem_stream_pkg: state enum (IDLE, ISSUE, DRAIN); constants AW=20 and default N=24.
- Sub-module sync_fifo: parameters WIDTH and DEPTH; ports clk, rst, push, push_data, pop, pop_data, empty, full, count. Instantiated with WIDTH=N+1.
- Top level holds the FSM, counters, credit logic, and in-flight flag.

Test Plan:
- Basic burst: memory preloaded with mem[0x10..0x12]=0xA1,0xB2,0xC3; start, base=0x00010, length=3, out_ready=1.
  - Expect out_data 0xA1,0xB2,0xC3 on consecutive cycles, starting 3 cycles after start.
  - Expect out_last only on 0xC3.
  - Expect a done pulse after the last beat; mem_wren=0 throughout.
- Backpressure: length=8, out_ready toggling 1,0,0,1,...
  - Expect all 8 words in order, none lost or duplicated.
  - Expect out_data stable while stalled and inflight+fifo_count ≤ 4 at all times.
- Wrap-around: base=0xFFFFE, length=4.
  - Expect mem_address sequence 0xFFFFE, 0xFFFFF, 0x00000, 0x00001, with matching data.
- Zero length: start with length=0.
  - Expect done=1 the next cycle, busy never high, no address change, out_valid=0.
- Reset mid-burst: rst=1 for 1 cycle after the 2nd beat of a length-6 burst.
  - Expect out_valid=0, busy=0, no done pulse.
  - A new burst, base=0x00100 length=2, then completes correctly.
- Start while busy: a second start during a length-4 burst.
  - Expect it ignored: exactly 4 beats, one done pulse.
